// File: rtl/pxconv_ring.sv
// ----------------------------------------------------------------------------
// pxconv_ring
//
// Converts a pixel stream (RGB565, RGB888 or grey8) to 8-bit luma and writes
// one luma word per BRAM entry into an NLINES-line ring buffer. A pixel-exact
// free-space credit throttles the upstream AXI reader, and the block reports
// when enough completed lines are resident to form a processing window.
//
// Ports:
//   clk, rst      - clock; synchronous active-high reset
//   px_data       - pixel: RGB565 in [15:0], RGB888 as {R,G,B}, grey8 in [7:0]
//   px_valid      - pixel valid
//   px_ready      - pixel accepted when px_valid & px_ready
//   fmt           - 0=RGB565, 1=RGB888, 2/3=grey8 (sampled per accepted pixel)
//   line_ack      - one-cycle pulse releasing the oldest resident line
//   rd_req        - AXI engine may issue one burst of rd_len pixels
//   rd_len        - burst length (constant BURST)
//   bram_we       - BRAM write strobe
//   bram_addr     - BRAM word address (BRAM_BASE + write pointer)
//   bram_data     - {24'b0, grey}
//   lines_avail   - completed, unreleased lines in the ring
//   wnd_in_bram   - lines_avail >= WIN_LINES
//   frame_done    - pulses with the write of the last pixel of a frame
//   ack_err       - sticky: line_ack seen while no line was resident
//   busy          - conversion pipeline holds a valid pixel
// ----------------------------------------------------------------------------
module pxconv_ring #(
  parameter int          HRES      = 640,
  parameter int          VRES      = 480,
  parameter int          NLINES    = 8,
  parameter int          WIN_LINES = 3,
  parameter int          BURST     = 128,
  parameter logic [31:0] BRAM_BASE = 32'd0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [23:0]                   px_data,
  input  logic                          px_valid,
  output logic                          px_ready,
  input  logic [1:0]                    fmt,
  input  logic                          line_ack,
  output logic                          rd_req,
  output logic [11:0]                   rd_len,
  output logic                          bram_we,
  output logic [31:0]                   bram_addr,
  output logic [31:0]                   bram_data,
  output logic [$clog2(NLINES+1)-1:0]   lines_avail,
  output logic                          wnd_in_bram,
  output logic                          frame_done,
  output logic                          ack_err,
  output logic                          busy
);

  localparam int TOTAL = NLINES * HRES;
  localparam int FW    = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(TOTAL);
  localparam int CW    = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int RW    = (VRES > 1) ? $clog2(VRES) : 1;
  localparam int LW    = $clog2(NLINES + 1);

  // Credit / handshake
  logic [FW-1:0] free_cnt_reg, free_cnt_next;
  logic          rd_req_reg;
  logic          accept;
  logic          ack_ok;

  // Stage 1: expanded colour (grey8 pixels travel in s1_r_reg)
  logic          s1_valid_reg;
  logic          s1_grey_reg;
  logic [7:0]    s1_r_reg, s1_g_reg, s1_b_reg;
  logic [7:0]    exp_r, exp_g, exp_b;
  logic          exp_grey;

  // Stage 2 / write side
  logic          bram_we_reg;
  logic [31:0]   bram_addr_reg;
  logic [31:0]   bram_data_reg;
  logic          frame_done_reg;
  logic [AW-1:0] wp_reg;
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic          col_last, row_last, line_done;
  logic [15:0]   luma_sum;
  logic [7:0]    luma;

  // Line bookkeeping
  logic [LW-1:0] lines_avail_reg, lines_avail_next;
  logic          wnd_reg;
  logic          ack_err_reg;

  assign px_ready = !rst && (free_cnt_reg != '0);
  assign accept   = px_valid && px_ready;
  assign ack_ok   = line_ack && (lines_avail_reg != '0);

  // Net credit change when a pixel is accepted and a line is released together
  always_comb begin
    free_cnt_next = free_cnt_reg;
    if (accept) free_cnt_next = free_cnt_next - FW'(1);
    if (ack_ok) free_cnt_next = free_cnt_next + FW'(HRES);
  end

  // Colour expansion: low bits replicate the MSBs so full-scale maps to 255
  always_comb begin
    exp_r    = 8'd0;
    exp_g    = 8'd0;
    exp_b    = 8'd0;
    exp_grey = 1'b0;
    case (fmt)
      2'd0: begin
        exp_r = {px_data[15:11], px_data[15:13]};
        exp_g = {px_data[10:5],  px_data[10:9]};
        exp_b = {px_data[4:0],   px_data[4:2]};
      end
      2'd1: begin
        exp_r = px_data[23:16];
        exp_g = px_data[15:8];
        exp_b = px_data[7:0];
      end
      default: begin
        exp_r    = px_data[7:0];
        exp_grey = 1'b1;
      end
    endcase
  end

  // Weights sum to 256, so the 16-bit sum peaks at 65280 and never wraps
  assign luma_sum = 16'd77  * {8'd0, s1_r_reg}
                  + 16'd150 * {8'd0, s1_g_reg}
                  + 16'd29  * {8'd0, s1_b_reg};
  assign luma     = s1_grey_reg ? s1_r_reg : luma_sum[15:8];

  assign col_last  = (col_reg == CW'(HRES - 1));
  assign row_last  = (row_reg == RW'(VRES - 1));
  assign line_done = s1_valid_reg && col_last;

  always_comb begin
    lines_avail_next = lines_avail_reg;
    case ({line_done, ack_ok})
      2'b10:   lines_avail_next = lines_avail_reg + LW'(1);
      2'b01:   lines_avail_next = lines_avail_reg - LW'(1);
      default: lines_avail_next = lines_avail_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      free_cnt_reg    <= FW'(TOTAL);
      rd_req_reg      <= 1'b0;
      s1_valid_reg    <= 1'b0;
      s1_grey_reg     <= 1'b0;
      s1_r_reg        <= 8'd0;
      s1_g_reg        <= 8'd0;
      s1_b_reg        <= 8'd0;
      bram_we_reg     <= 1'b0;
      bram_addr_reg   <= BRAM_BASE;
      bram_data_reg   <= 32'd0;
      frame_done_reg  <= 1'b0;
      wp_reg          <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      lines_avail_reg <= '0;
      wnd_reg         <= 1'b0;
      ack_err_reg     <= 1'b0;
    end else begin
      free_cnt_reg <= free_cnt_next;
      rd_req_reg   <= (free_cnt_next >= FW'(BURST));

      s1_valid_reg <= accept;
      if (accept) begin
        s1_grey_reg <= exp_grey;
        s1_r_reg    <= exp_r;
        s1_g_reg    <= exp_g;
        s1_b_reg    <= exp_b;
      end

      bram_we_reg    <= s1_valid_reg;
      frame_done_reg <= s1_valid_reg && col_last && row_last;
      if (s1_valid_reg) begin
        bram_addr_reg <= BRAM_BASE + 32'(wp_reg);
        bram_data_reg <= {24'd0, luma};
        wp_reg        <= (wp_reg == AW'(TOTAL - 1)) ? '0 : wp_reg + AW'(1);
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + RW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
      end

      lines_avail_reg <= lines_avail_next;
      wnd_reg         <= (lines_avail_next >= LW'(WIN_LINES));
      if (line_ack && (lines_avail_reg == '0)) ack_err_reg <= 1'b1;
    end
  end

  assign rd_req      = rd_req_reg;
  assign rd_len      = 12'(BURST);
  assign bram_we     = bram_we_reg;
  assign bram_addr   = bram_addr_reg;
  assign bram_data   = bram_data_reg;
  assign lines_avail = lines_avail_reg;
  assign wnd_in_bram = wnd_reg;
  assign frame_done  = frame_done_reg;
  assign ack_err     = ack_err_reg;
  assign busy        = s1_valid_reg || bram_we_reg;

endmodule

// File: tb/tb_pxconv_ring.sv
// ----------------------------------------------------------------------------
// tb_pxconv_ring
//
// Directed bench for pxconv_ring with HRES=8, VRES=4, NLINES=2, WIN_LINES=2,
// BURST=4, BRAM_BASE=0x100. Inputs change and outputs are sampled on the
// falling clock edge; each scenario task makes its own comparisons.
// ----------------------------------------------------------------------------
module tb_pxconv_ring;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic [1:0]  fmt;
  logic        line_ack;
  logic        rd_req;
  logic [11:0] rd_len;
  logic        bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_data;
  logic [1:0]  lines_avail;
  logic        wnd_in_bram;
  logic        frame_done;
  logic        ack_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  pxconv_ring #(
    .HRES(8), .VRES(4), .NLINES(2), .WIN_LINES(2), .BURST(4),
    .BRAM_BASE(32'h100)
  ) dut (
    .clk(clk), .rst(rst),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready), .fmt(fmt),
    .line_ack(line_ack),
    .rd_req(rd_req), .rd_len(rd_len),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_data(bram_data),
    .lines_avail(lines_avail), .wnd_in_bram(wnd_in_bram),
    .frame_done(frame_done), .ack_err(ack_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; px_valid = 1'b0; line_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Present one pixel for one cycle; returns on the falling edge after accept.
  task automatic send_px(input logic [23:0] d, input logic [1:0] f);
    px_data = d; fmt = f; px_valid = 1'b1;
    @(negedge clk);
    px_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; px_valid = 1'b1; px_data = 24'h123456; fmt = 2'd0; line_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (px_ready !== 1'b0) begin n_err++; $display("FAIL reset_px_ready got %0b want 0", px_ready); end
    n_vec++; if (rd_req !== 1'b0) begin n_err++; $display("FAIL reset_rd_req got %0b want 0", rd_req); end
    n_vec++; if (rd_len !== 12'd4) begin n_err++; $display("FAIL reset_rd_len got %0d want 4", rd_len); end
    n_vec++; if (bram_we !== 1'b0 || bram_addr !== 32'h100 || bram_data !== 32'd0) begin
      n_err++; $display("FAIL reset_bram got we=%0b addr=%h data=%h want 0/100/0", bram_we, bram_addr, bram_data); end
    n_vec++; if ({lines_avail, wnd_in_bram, frame_done, ack_err, busy} !== 6'b0) begin
      n_err++; $display("FAIL reset_status got la=%0d wnd=%0b fd=%0b ae=%0b busy=%0b want all 0",
                        lines_avail, wnd_in_bram, frame_done, ack_err, busy); end
    px_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (rd_req !== 1'b1 || px_ready !== 1'b1) begin
      n_err++; $display("FAIL post_reset got rd_req=%0b px_ready=%0b want 1/1", rd_req, px_ready); end
    $display("test_reset done");
  endtask

  task automatic test_convert();
    logic [23:0] vd [7] = '{24'h00FFFF, 24'h00F800, 24'h0007E0, 24'h00001F, 24'h000000, 24'hFF0000, 24'h00005A};
    logic [1:0]  vf [7] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    logic [31:0] ve [7] = '{32'd255, 32'd76, 32'd149, 32'd28, 32'd0, 32'd76, 32'h5A};
    for (int i = 0; i < 7; i++) begin
      send_px(vd[i], vf[i]);
      n_vec++; if (busy !== 1'b1 || bram_we !== 1'b0) begin
        n_err++; $display("FAIL conv_t1[%0d] got busy=%0b we=%0b want 1/0", i, busy, bram_we); end
      @(negedge clk);
      n_vec++; if (bram_we !== 1'b1 || bram_data !== ve[i] || bram_addr !== 32'h100 + 32'(i)) begin
        n_err++; $display("FAIL conv[%0d] got we=%0b data=%0d addr=%h want 1/%0d/%h",
                          i, bram_we, bram_data, bram_addr, ve[i], 32'h100 + 32'(i)); end
      $display("convert px=%h fmt=%0d -> grey=%0d", vd[i], vf[i], bram_data);
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_addr = 32'h100;
    int nw = 0;
    bit seen1 = 1'b0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      px_valid = (c < 16); px_data = 24'(c); fmt = 2'd2;
      @(negedge clk);
      if (bram_we) begin
        n_vec++; if (bram_addr !== exp_addr || bram_data !== 32'(nw)) begin
          n_err++; $display("FAIL fill_write[%0d] got addr=%h data=%0d want %h/%0d", nw, bram_addr, bram_data, exp_addr, nw); end
        $display("fill write addr=%h data=%0d lines_avail=%0d", bram_addr, bram_data, lines_avail);
        exp_addr++; nw++;
      end
      if (lines_avail == 2'd1) seen1 = 1'b1;
    end
    n_vec++; if (nw != 16 || !seen1) begin n_err++; $display("FAIL fill_count got writes=%0d seen1=%0b want 16/1", nw, seen1); end
    n_vec++; if (lines_avail !== 2'd2 || wnd_in_bram !== 1'b1) begin
      n_err++; $display("FAIL fill_lines got la=%0d wnd=%0b want 2/1", lines_avail, wnd_in_bram); end
    px_valid = 1'b1; px_data = 24'hAA; fmt = 2'd2;
    n_vec++; if (px_ready !== 1'b0 || rd_req !== 1'b0) begin
      n_err++; $display("FAIL fill_full got px_ready=%0b rd_req=%0b want 0/0", px_ready, rd_req); end
    repeat (2) @(negedge clk);
    n_vec++; if (bram_we !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL fill_noaccept got we=%0b busy=%0b want 0/0", bram_we, busy); end
    px_valid = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr = 32'h100;
    int nw = 0;
    line_ack = 1'b1;
    @(negedge clk);
    line_ack = 1'b0;
    n_vec++; if (rd_req !== 1'b1 || px_ready !== 1'b1 || lines_avail !== 2'd1 || wnd_in_bram !== 1'b0) begin
      n_err++; $display("FAIL wrap_ack got rd_req=%0b px_ready=%0b la=%0d wnd=%0b want 1/1/1/0",
                        rd_req, px_ready, lines_avail, wnd_in_bram); end
    for (int c = 0; c < 12; c++) begin
      px_valid = (c < 8); px_data = 24'(c + 8'h40); fmt = 2'd3;
      @(negedge clk);
      if (bram_we) begin
        n_vec++; if (bram_addr !== exp_addr) begin
          n_err++; $display("FAIL wrap_addr[%0d] got %h want %h", nw, bram_addr, exp_addr); end
        $display("wrap write addr=%h data=%0d", bram_addr, bram_data);
        exp_addr++; nw++;
      end
    end
    n_vec++; if (nw != 8 || lines_avail !== 2'd2 || px_ready !== 1'b0) begin
      n_err++; $display("FAIL wrap_end got writes=%0d la=%0d px_ready=%0b want 8/2/0", nw, lines_avail, px_ready); end
  endtask

  task automatic test_frame();
    int fd_cnt = 0;
    bit fd_last = 1'b0;
    do_reset();
    for (int p = 0; p < 32; p++) begin
      send_px(24'(p), 2'd2);
      @(negedge clk);
      if (frame_done) begin fd_cnt++; if (p == 31 && bram_we) fd_last = 1'b1; end
      if (p % 8 == 7) begin
        $display("frame line %0d complete addr=%h la=%0d fd=%0b", p / 8, bram_addr, lines_avail, frame_done);
        line_ack = 1'b1;
        @(negedge clk);
        line_ack = 1'b0;
        if (frame_done) fd_cnt++;
      end
    end
    n_vec++; if (fd_cnt != 1 || !fd_last) begin
      n_err++; $display("FAIL frame_done got pulses=%0d on_last=%0b want 1/1", fd_cnt, fd_last); end
    n_vec++; if (lines_avail !== 2'd0 || ack_err !== 1'b0) begin
      n_err++; $display("FAIL frame_lines got la=%0d ae=%0b want 0/0", lines_avail, ack_err); end
    // A fresh line must complete exactly on its 8th pixel with no frame pulse.
    for (int p = 0; p < 8; p++) begin
      send_px(24'(p), 2'd2);
      @(negedge clk);
      if (p == 0) begin
        n_vec++; if (bram_addr !== 32'h100) begin n_err++; $display("FAIL frame_next_addr got %h want 100", bram_addr); end
      end
      if (p == 6) begin
        n_vec++; if (lines_avail !== 2'd0) begin n_err++; $display("FAIL frame_col7 got la=%0d want 0", lines_avail); end
      end
    end
    n_vec++; if (lines_avail !== 2'd1 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL frame_nextline got la=%0d fd=%0b want 1/0", lines_avail, frame_done); end
  endtask

  task automatic test_ack_err();
    do_reset();
    line_ack = 1'b1;
    @(negedge clk);
    line_ack = 1'b0;
    n_vec++; if (ack_err !== 1'b1 || lines_avail !== 2'd0) begin
      n_err++; $display("FAIL ack_err_set got ae=%0b la=%0d want 1/0", ack_err, lines_avail); end
    for (int p = 0; p < 8; p++) begin send_px(24'(p), 2'd2); @(negedge clk); end
    n_vec++; if (lines_avail !== 2'd1) begin n_err++; $display("FAIL ack_line1 got la=%0d want 1", lines_avail); end
    for (int p = 0; p < 7; p++) begin send_px(24'(p), 2'd2); @(negedge clk); end
    px_data = 24'h7; fmt = 2'd2; px_valid = 1'b1;
    @(negedge clk);
    px_valid = 1'b0; line_ack = 1'b1;
    @(negedge clk);
    line_ack = 1'b0;
    $display("ack with completion: we=%0b la=%0d ae=%0b", bram_we, lines_avail, ack_err);
    n_vec++; if (bram_we !== 1'b1 || lines_avail !== 2'd1 || ack_err !== 1'b1 || px_ready !== 1'b1) begin
      n_err++; $display("FAIL ack_same_cycle got we=%0b la=%0d ae=%0b px_ready=%0b want 1/1/1/1",
                        bram_we, lines_avail, ack_err, px_ready); end
  endtask

  task automatic test_rst_flush();
    int nw = 0;
    do_reset();
    for (int p = 0; p < 3; p++) begin send_px(24'(p), 2'd2); @(negedge clk); end
    px_data = 24'h00F800; fmt = 2'd0; px_valid = 1'b1;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy got %0b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    n_vec++; if (bram_we !== 1'b0 || busy !== 1'b0 || px_ready !== 1'b0 || rd_req !== 1'b0 ||
                 bram_addr !== 32'h100 || bram_data !== 32'd0 || lines_avail !== 2'd0) begin
      n_err++; $display("FAIL flush_state got we=%0b busy=%0b rdy=%0b rd_req=%0b addr=%h data=%h la=%0d want reset values",
                        bram_we, busy, px_ready, rd_req, bram_addr, bram_data, lines_avail); end
    px_valid = 1'b0;
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (bram_we) nw++; end
    n_vec++; if (nw != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_nowrite got writes=%0d busy=%0b want 0/0", nw, busy); end
    $display("reset flush: writes after reset=%0d", nw);
  endtask

  initial begin
    rst = 1'b1; px_valid = 1'b0; px_data = '0; fmt = '0; line_ack = 1'b0;
    test_reset();
    test_convert();
    test_fill();
    test_wrap();
    test_frame();
    test_ack_err();
    test_rst_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
